// File: rtl/clock_divider_multi.sv
// NUM_CH independent programmable clock dividers on one input clock, each with a
// runtime divisor that is swapped in only at a period boundary (glitch-free).
module clock_divider_multi #(
    parameter int               NUM_CH      = 4,
    parameter int               CH_W        = 2,
    parameter int               CNT_W       = 28,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = 28'd100000
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] enable,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] clock_out,
    output logic [NUM_CH-1:0] tick
);

    localparam int               NUM_SLOT = 1 << CH_W;
    localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);

    function automatic logic [CNT_W-1:0] coerce_div(input logic [CNT_W-1:0] d);
        if (d < MIN_DIV) begin
            coerce_div = MIN_DIV;
        end else begin
            coerce_div = d;
        end
    endfunction

    logic [CNT_W-1:0]  cnt_r        [NUM_CH];
    logic [CNT_W-1:0]  div_r        [NUM_CH];
    logic [CNT_W-1:0]  shadow_r     [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt_s    [NUM_CH];
    logic [CNT_W-1:0]  div_nxt_s    [NUM_CH];
    logic [CNT_W-1:0]  shadow_nxt_s [NUM_CH];
    logic [NUM_CH-1:0] pending_r;
    logic [NUM_CH-1:0] pending_nxt_s;
    logic [NUM_CH-1:0] clock_out_nxt_s;
    logic [NUM_CH-1:0] tick_nxt_s;
    logic [NUM_CH-1:0] wrap_s;
    logic [NUM_CH-1:0] accept_s;
    logic [NUM_SLOT-1:0] pend_slot_s;
    logic              cfg_ready_s;

    // Unused channel slots read as never pending, so writes there are accepted and dropped.
    always_comb begin
        pend_slot_s             = '0;
        pend_slot_s[NUM_CH-1:0] = pending_r;
        cfg_ready_s             = reset_n & ~pend_slot_s[cfg_ch];
    end

    assign cfg_ready = cfg_ready_s;

    // Per-channel next state: count, output decode, divisor apply and config accept.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_nxt_s[c]       = cnt_r[c];
            div_nxt_s[c]       = div_r[c];
            shadow_nxt_s[c]    = shadow_r[c];
            pending_nxt_s[c]   = pending_r[c];
            clock_out_nxt_s[c] = 1'b0;
            tick_nxt_s[c]      = 1'b0;
            wrap_s[c]          = (cnt_r[c] == (div_r[c] - CNT_W'(1)));
            accept_s[c]        = cfg_valid & cfg_ready_s & (cfg_ch == CH_W'(c));

            if (enable[c]) begin
                clock_out_nxt_s[c] = (cnt_r[c] < (div_r[c] >> 1));
                tick_nxt_s[c]      = wrap_s[c];
                if (wrap_s[c]) begin
                    cnt_nxt_s[c] = '0;
                    if (pending_r[c]) begin
                        div_nxt_s[c]     = shadow_r[c];
                        pending_nxt_s[c] = 1'b0;
                    end else begin
                        div_nxt_s[c] = div_r[c];
                    end
                end else begin
                    cnt_nxt_s[c] = cnt_r[c] + CNT_W'(1);
                end
            end else begin
                // A stopped channel has no period to protect, so apply at once.
                cnt_nxt_s[c] = '0;
                if (pending_r[c]) begin
                    div_nxt_s[c]     = shadow_r[c];
                    pending_nxt_s[c] = 1'b0;
                end else begin
                    div_nxt_s[c] = div_r[c];
                end
            end

            // Accept only happens while not pending, so it never races an apply.
            if (accept_s[c]) begin
                shadow_nxt_s[c]  = coerce_div(cfg_div);
                pending_nxt_s[c] = 1'b1;
            end else begin
                shadow_nxt_s[c] = shadow_r[c];
            end
        end
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_r[c]    <= '0;
                div_r[c]    <= DEFAULT_DIV;
                shadow_r[c] <= '0;
            end
            pending_r <= '0;
            clock_out <= '0;
            tick      <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_r[c]    <= cnt_nxt_s[c];
                div_r[c]    <= div_nxt_s[c];
                shadow_r[c] <= shadow_nxt_s[c];
            end
            pending_r <= pending_nxt_s;
            clock_out <= clock_out_nxt_s;
            tick      <= tick_nxt_s;
        end
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: directed scenarios plus random traffic, checked
// against a period-timeline model (absolute period start time and length per channel).
module tb_clock_divider_multi;

    localparam int          NUM_CH = 4;
    localparam int          CH_W   = 2;
    localparam int          CNT_W  = 28;
    localparam logic [27:0] DDIV   = 28'd10;

    logic              clock_in = 1'b0;
    logic              reset_n;
    logic [NUM_CH-1:0] enable;
    logic              cfg_valid;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_ready;
    logic [NUM_CH-1:0] clock_out;
    logic [NUM_CH-1:0] tick;

    always #5 clock_in = ~clock_in;

    clock_divider_multi #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W), .DEFAULT_DIV(DDIV)
    ) dut (
        .clock_in(clock_in), .reset_n(reset_n), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .clock_out(clock_out), .tick(tick)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: each channel's current period began at edge pstart and lasts per edges.
    int pstart [NUM_CH];
    int per    [NUM_CH];
    int shad   [NUM_CH];
    bit pend   [NUM_CH];
    bit last_accept;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    endtask

    task automatic step();
        logic [NUM_CH-1:0] eco;
        logic [NUM_CH-1:0] etk;
        bit rdy;
        int pos;
        #1;
        rdy = reset_n && ((int'(cfg_ch) >= NUM_CH) || !pend[cfg_ch]);
        check_val("cfg_ready", {31'd0, cfg_ready}, {31'd0, rdy});
        last_accept = 1'b0;
        eco = '0;
        etk = '0;
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pstart[c] = cyc + 1;
                per[c]    = int'(DDIV);
                shad[c]   = 0;
                pend[c]   = 1'b0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                pos = cyc - pstart[c];
                if (enable[c]) begin
                    eco[c] = (pos < per[c] / 2);
                    etk[c] = (pos == per[c] - 1);
                    if (pos == per[c] - 1) begin
                        pstart[c] = cyc + 1;
                        if (pend[c]) begin per[c] = shad[c]; pend[c] = 1'b0; end
                    end
                end else begin
                    pstart[c] = cyc + 1;
                    if (pend[c]) begin per[c] = shad[c]; pend[c] = 1'b0; end
                end
            end
            if (cfg_valid && rdy && int'(cfg_ch) < NUM_CH) begin
                shad[cfg_ch] = (cfg_div < 2) ? 2 : int'(cfg_div);
                pend[cfg_ch] = 1'b1;
                last_accept  = 1'b1;
            end
        end
        @(posedge clock_in);
        #1;
        cyc++;
        check_val("clock_out", {28'd0, clock_out}, {28'd0, eco});
        check_val("tick", {28'd0, tick}, {28'd0, etk});
    endtask

    initial begin
        int hi, tk;
        bit got;
        reset_n   = 1'b0;
        enable    = '0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (2) step();

        // Default divisor: 5 high / 5 low, tick every 10 cycles, first high right away.
        enable = '1;
        hi = 0; tk = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            hi += int'(clock_out[0]);
            tk += int'(tick[0]);
        end
        check_val("t1_high_cycles", hi, 10);
        check_val("t1_ticks", tk, 2);

        // Mid-period write to ch1, then a second write held off while pending.
        repeat (3) step();
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 28'd7;
        step();
        check_val("t2_accept", {31'd0, last_accept}, 32'd1);
        cfg_div = 28'd5;
        step();
        check_val("t3_held", {31'd0, last_accept}, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = last_accept;
        end
        check_val("t3_second_accept", {31'd0, got}, 32'd1);
        cfg_valid = 1'b0;
        repeat (20) step();

        // Divisors 0 and 1 coerce to 2.
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 28'd0;
        step();
        cfg_ch = 2'd0; cfg_div = 28'd1;
        step();
        cfg_valid = 1'b0;
        repeat (30) step();
        hi = 0; tk = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            hi += int'(clock_out[3]);
            tk += int'(tick[3]);
        end
        check_val("t4_div2_high", hi, 5);
        check_val("t4_div2_ticks", tk, 5);

        // Drop enable[2] while high, then re-enable.
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = clock_out[2];
        end
        check_val("t5_found_high", {31'd0, got}, 32'd1);
        enable[2] = 1'b0;
        step();
        check_val("t5_off", {31'd0, clock_out[2]}, 32'd0);
        repeat (4) step();
        enable[2] = 1'b1;
        repeat (25) step();

        // Reset with a pending write and running counters.
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 28'd3;
        step();
        cfg_valid = 1'b0;
        reset_n = 1'b0;
        step();
        check_val("t6_outputs_zero", {24'd0, clock_out, tick}, 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (25) step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 100 == 0) enable[$urandom % NUM_CH] = ~enable[$urandom % NUM_CH];
            cfg_valid = ($urandom % 8 == 0);
            cfg_ch    = CH_W'($urandom % NUM_CH);
            cfg_div   = CNT_W'($urandom_range(0, 16));
            reset_n   = ($urandom % 400 != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
